// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types for the CPU/DMA shared-RAM bus arbiter.
//   state_t : arbiter FSM states (IDLE, CPU_GNT, DMA_GNT, TURN)
//   owner_t : which master held the bus most recently (CPU, DMA)
// ---------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_GNT = 2'd1,
        DMA_GNT = 2'd2,
        TURN    = 2'd3
    } state_t;

    typedef enum logic {
        CPU = 1'b0,
        DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master (CPU, DMA) arbiter for a shared RAM bus. Grants come from a
// registered FSM, and ties go to the master that was not served last. A burst
// counter stops one master from holding the bus for more than MAX_BURST
// consecutive cycles while the other master is waiting. Every handover passes
// through a one-cycle TURN gap in which the bus is idle.
//
// Ports
//   Clk, Rst                       clock, synchronous active-high reset
//   Cpu_bus_req / Dma_bus_req      bus requests
//   Cpu_* / Dma_* address, strobes, write data from each master
//   Cpu_bus_grant / Dma_bus_grant  registered grants (mutually exclusive)
//   Address, Cs, Wr_en, Oe,
//   Databus_out                    owner's bus signals, zero when no owner
//   Burst_preempt                  one-cycle pulse when the burst limit
//                                  revokes a grant
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Cpu_bus_req,
    input  logic [ADDR_W-1:0] Cpu_address,
    input  logic              Cpu_cs,
    input  logic              Cpu_wr_en,
    input  logic              Cpu_oe,
    input  logic [DATA_W-1:0] Cpu_data_out,
    input  logic              Dma_bus_req,
    input  logic [ADDR_W-1:0] Dma_address,
    input  logic              Dma_cs,
    input  logic              Dma_wr_en,
    input  logic              Dma_oe,
    input  logic [DATA_W-1:0] Dma_data_out,
    output logic              Cpu_bus_grant,
    output logic              Dma_bus_grant,
    output logic [ADDR_W-1:0] Address,
    output logic              Cs,
    output logic              Wr_en,
    output logic              Oe,
    output logic [DATA_W-1:0] Databus_out,
    output logic              Burst_preempt
);

    // The counter only needs to reach MAX_BURST-1, where it saturates.
    localparam int               CNT_W   = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_t           state_q,     state_d;
    owner_t           lastOwner_q, lastOwner_d;
    logic [CNT_W-1:0] burstCnt_q,  burstCnt_d;
    logic             preempt_q,   preempt_d;

    // State register. Reset returns to IDLE immediately, so a grant that is
    // active when reset arrives is dropped without passing through TURN.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            lastOwner_q <= CPU;
            burstCnt_q  <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            burstCnt_q  <= burstCnt_d;
            preempt_q   <= preempt_d;
        end
    end

    // Next-state logic. IDLE and TURN make the same grant decision. TURN is
    // left after exactly one cycle because it never selects itself.
    // lastOwner is updated when a grant is entered. After reset it reads CPU,
    // so the first tie goes to DMA.
    always_comb begin
        state_d     = state_q;
        lastOwner_d = lastOwner_q;
        burstCnt_d  = burstCnt_q;
        preempt_d   = 1'b0;

        case (state_q)
            IDLE, TURN: begin
                state_d = IDLE;
                if (Dma_bus_req && (!Cpu_bus_req || lastOwner_q == CPU)) begin
                    state_d     = DMA_GNT;
                    lastOwner_d = DMA;
                    burstCnt_d  = '0;
                end else if (Cpu_bus_req) begin
                    state_d     = CPU_GNT;
                    lastOwner_d = CPU;
                    burstCnt_d  = '0;
                end
            end
            CPU_GNT: begin
                // A voluntary release takes priority over a burst preemption.
                if (!Cpu_bus_req) begin
                    state_d = TURN;
                end else if (burstCnt_q == CNT_MAX && Dma_bus_req) begin
                    state_d   = TURN;
                    preempt_d = 1'b1;
                end else if (burstCnt_q != CNT_MAX) begin
                    burstCnt_d = burstCnt_q + 1'b1;
                end
            end
            DMA_GNT: begin
                if (!Dma_bus_req) begin
                    state_d = TURN;
                end else if (burstCnt_q == CNT_MAX && Cpu_bus_req) begin
                    state_d   = TURN;
                    preempt_d = 1'b1;
                end else if (burstCnt_q != CNT_MAX) begin
                    burstCnt_d = burstCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Cpu_bus_grant = (state_q == CPU_GNT);
    assign Dma_bus_grant = (state_q == DMA_GNT);
    assign Burst_preempt = preempt_q;

    // Bus mux. It passes the owner's signals through combinationally and
    // drives the bus quiet (all zero) in IDLE and TURN.
    always_comb begin
        Address     = '0;
        Cs          = 1'b0;
        Wr_en       = 1'b0;
        Oe          = 1'b0;
        Databus_out = '0;
        if (state_q == CPU_GNT) begin
            Address     = Cpu_address;
            Cs          = Cpu_cs;
            Wr_en       = Cpu_wr_en;
            Oe          = Cpu_oe;
            Databus_out = Cpu_data_out;
        end else if (state_q == DMA_GNT) begin
            Address     = Dma_address;
            Cs          = Dma_cs;
            Wr_en       = Dma_wr_en;
            Oe          = Dma_oe;
            Databus_out = Dma_data_out;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. A reference model keeps the current
// owner, the number of cycles that owner has held the bus, and the master
// served last. It is checked every cycle next to table vectors, directed
// sequences and randomized request traffic.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int MAXB   = 16;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Cpu_bus_req, Cpu_cs, Cpu_wr_en, Cpu_oe;
    logic [ADDR_W-1:0] Cpu_address;
    logic [DATA_W-1:0] Cpu_data_out;
    logic              Dma_bus_req, Dma_cs, Dma_wr_en, Dma_oe;
    logic [ADDR_W-1:0] Dma_address;
    logic [DATA_W-1:0] Dma_data_out;
    logic              Cpu_bus_grant, Dma_bus_grant;
    logic [ADDR_W-1:0] Address;
    logic              Cs, Wr_en, Oe;
    logic [DATA_W-1:0] Databus_out;
    logic              Burst_preempt;

    always #5 Clk = ~Clk;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAXB)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Cpu_bus_req  (Cpu_bus_req),
        .Cpu_address  (Cpu_address),
        .Cpu_cs       (Cpu_cs),
        .Cpu_wr_en    (Cpu_wr_en),
        .Cpu_oe       (Cpu_oe),
        .Cpu_data_out (Cpu_data_out),
        .Dma_bus_req  (Dma_bus_req),
        .Dma_address  (Dma_address),
        .Dma_cs       (Dma_cs),
        .Dma_wr_en    (Dma_wr_en),
        .Dma_oe       (Dma_oe),
        .Dma_data_out (Dma_data_out),
        .Cpu_bus_grant(Cpu_bus_grant),
        .Dma_bus_grant(Dma_bus_grant),
        .Address      (Address),
        .Cs           (Cs),
        .Wr_en        (Wr_en),
        .Oe           (Oe),
        .Databus_out  (Databus_out),
        .Burst_preempt(Burst_preempt)
    );

    typedef struct {
        logic rst;
        logic cReq;
        logic dReq;
        logic expC;
        logic expD;
        logic expP;
    } vec_t;

    vec_t vecs[24];

    int   checks = 0;
    int   fails  = 0;
    logic fixAddr = 1'b0;

    // Model state: owner 0 = none, 1 = CPU, 2 = DMA.
    int   mOwner = 0;
    int   mHeld  = 0;
    int   mLast  = 1;
    logic mPre   = 1'b0;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge, using the request and reset
    // values the DUT samples at that same edge.
    task automatic modelStep();
        logic ownReq, othReq;
        if (Rst) begin
            mOwner = 0;
            mHeld  = 0;
            mLast  = 1;
            mPre   = 1'b0;
        end else begin
            mPre = 1'b0;
            if (mOwner != 0) begin
                ownReq = (mOwner == 1) ? Cpu_bus_req : Dma_bus_req;
                othReq = (mOwner == 1) ? Dma_bus_req : Cpu_bus_req;
                if (!ownReq) begin
                    mOwner = 0;
                end else if (mHeld >= MAXB && othReq) begin
                    mOwner = 0;
                    mPre   = 1'b1;
                end else begin
                    mHeld++;
                end
            end else begin
                if (Cpu_bus_req && Dma_bus_req) mOwner = (mLast == 1) ? 2 : 1;
                else if (Cpu_bus_req)           mOwner = 1;
                else if (Dma_bus_req)           mOwner = 2;
                if (mOwner != 0) begin
                    mHeld = 1;
                    mLast = mOwner;
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [ADDR_W-1:0] eAddr;
        logic [DATA_W-1:0] eData;
        logic              eCs, eWr, eOe;
        eAddr = '0; eData = '0; eCs = 1'b0; eWr = 1'b0; eOe = 1'b0;
        if (mOwner == 1) begin
            eAddr = Cpu_address; eData = Cpu_data_out;
            eCs = Cpu_cs; eWr = Cpu_wr_en; eOe = Cpu_oe;
        end else if (mOwner == 2) begin
            eAddr = Dma_address; eData = Dma_data_out;
            eCs = Dma_cs; eWr = Dma_wr_en; eOe = Dma_oe;
        end
        compare("cpu_grant",   32'(Cpu_bus_grant), 32'(mOwner == 1));
        compare("dma_grant",   32'(Dma_bus_grant), 32'(mOwner == 2));
        compare("preempt",     32'(Burst_preempt), 32'(mPre));
        compare("address",     32'(Address),       32'(eAddr));
        compare("databus",     32'(Databus_out),   32'(eData));
        compare("strobes",     {29'd0, Cs, Wr_en, Oe}, {29'd0, eCs, eWr, eOe});
        compare("grant_excl",  32'(Cpu_bus_grant & Dma_bus_grant), 32'd0);
        compare("cs_no_grant", 32'(!Cpu_bus_grant && !Dma_bus_grant && Cs), 32'd0);
    endtask

    // Drive one cycle of inputs at the falling edge, let the DUT and the model
    // see the rising edge, then check at the following falling edge.
    task automatic applyStimulus(input logic rst, input logic cReq, input logic dReq);
        Rst          = rst;
        Cpu_bus_req  = cReq;
        Dma_bus_req  = dReq;
        Cpu_address  = fixAddr ? 8'h3C : ADDR_W'($urandom);
        Dma_address  = ADDR_W'($urandom);
        Cpu_data_out = DATA_W'($urandom);
        Dma_data_out = DATA_W'($urandom);
        Cpu_cs       = fixAddr ? 1'b1 : 1'($urandom_range(0, 1));
        Dma_cs       = 1'($urandom_range(0, 1));
        Cpu_wr_en    = 1'($urandom_range(0, 1));
        Dma_wr_en    = 1'($urandom_range(0, 1));
        Cpu_oe       = 1'($urandom_range(0, 1));
        Dma_oe       = 1'($urandom_range(0, 1));
        @(posedge Clk);
        modelStep();
        @(negedge Clk);
        checkOutput();
    endtask

    initial begin
        int   pulses;
        logic c, d;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        Rst = 1'b1; Cpu_bus_req = 1'b0; Dma_bus_req = 1'b0;
        Cpu_address = '0; Dma_address = '0; Cpu_data_out = '0; Dma_data_out = '0;
        Cpu_cs = 1'b0; Cpu_wr_en = 1'b0; Cpu_oe = 1'b0;
        Dma_cs = 1'b0; Dma_wr_en = 1'b0; Dma_oe = 1'b0;
        @(negedge Clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        compare("reset_cpu_grant", 32'(Cpu_bus_grant), 32'd0);
        compare("reset_dma_grant", 32'(Dma_bus_grant), 32'd0);
        compare("reset_address",   32'(Address),       32'd0);

        // Table vectors: each row gives the inputs for one edge and the
        // grants/preempt expected after that edge.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].cReq, vecs[i].dReq);
            compare($sformatf("tbl%0d_cpu", i), 32'(Cpu_bus_grant), 32'(vecs[i].expC));
            compare($sformatf("tbl%0d_dma", i), 32'(Dma_bus_grant), 32'(vecs[i].expD));
            compare($sformatf("tbl%0d_pre", i), 32'(Burst_preempt), 32'(vecs[i].expP));
        end

        // Lone CPU request: request on cycles 5..9, Address follows 8'h3C.
        applyStimulus(1'b1, 1'b0, 1'b0);
        fixAddr = 1'b1;
        for (int k = 0; k < 13; k++) begin
            c = (k >= 5 && k < 10);
            applyStimulus(1'b0, c, 1'b0);
            compare($sformatf("lone_gnt%0d", k), 32'(Cpu_bus_grant), 32'(c));
            compare($sformatf("lone_addr%0d", k), 32'(Address), c ? 32'h3C : 32'd0);
            compare($sformatf("lone_cs%0d", k), 32'(Cs), 32'(c));
        end
        fixAddr = 1'b0;

        // Tie after reset goes to DMA; a DMA release causes a TURN cycle,
        // and then CPU is granted.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, k >= 3, k >= 3 && k < 7);
            compare($sformatf("tie_dma%0d", k), 32'(Dma_bus_grant), 32'(k >= 3 && k <= 6));
            compare($sformatf("tie_cpu%0d", k), 32'(Cpu_bus_grant), 32'(k >= 8));
        end

        // Burst limit with both masters requesting: grants alternate every
        // MAXB cycles, with one preempt pulse in each gap.
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 37; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (k <= 32 && Burst_preempt) pulses++;
            compare($sformatf("burst_dma%0d", k), 32'(Dma_bus_grant), 32'(k <= 15 || k >= 34));
            compare($sformatf("burst_cpu%0d", k), 32'(Cpu_bus_grant), 32'(k >= 17 && k <= 32));
            compare($sformatf("burst_pre%0d", k), 32'(Burst_preempt), 32'(k == 16 || k == 33));
        end
        compare("burst_pulse_count", 32'(pulses), 32'd1);

        // No contention: DMA keeps the bus for 40 cycles and is never preempted.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            compare($sformatf("solo_dma%0d", k), 32'(Dma_bus_grant), 32'd1);
            compare($sformatf("solo_pre%0d", k), 32'(Burst_preempt), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset in the middle of a CPU grant, then a tie goes to DMA.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        compare("rstmid_pre_cpu", 32'(Cpu_bus_grant), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        compare("rstmid_cpu",  32'(Cpu_bus_grant), 32'd0);
        compare("rstmid_dma",  32'(Dma_bus_grant), 32'd0);
        compare("rstmid_cs",   32'(Cs),            32'd0);
        compare("rstmid_addr", 32'(Address),       32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        compare("rstmid_tie_dma", 32'(Dma_bus_grant), 32'd1);

        // Random traffic: requests are sticky so that bursts and preemptions
        // occur, with an occasional reset.
        applyStimulus(1'b1, 1'b0, 1'b0);
        c = 1'b0; d = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) c = ~c;
            if ($urandom_range(0, 5) == 0) d = ~d;
            applyStimulus($urandom_range(0, 299) == 0, c, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, bus address width.
REQ-002 SHALL have parameter DATA_W, default 8, bus data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, max consecutive grant cycles while the other master waits; legal range 2..255.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports, clock and reset first:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous active-high reset
- Cpu_bus_req  in  1  CPU requests shared RAM bus
- Cpu_address  in  ADDR_W  CPU address
- Cpu_cs / Cpu_wr_en / Cpu_oe  in  1 each  CPU strobes
- Cpu_data_out  in  DATA_W  CPU write data
- Dma_bus_req  in  1  DMA requests bus, from the DMA channel mux
- Dma_address  in  ADDR_W  DMA address
- Dma_cs / Dma_wr_en / Dma_oe  in  1 each  DMA strobes
- Dma_data_out  in  DATA_W  DMA write data
- Cpu_bus_grant  out  1  CPU owns bus
- Dma_bus_grant  out  1  DMA owns bus
- Address  out  ADDR_W  muxed RAM address
- Cs / Wr_en / Oe  out  1 each  muxed RAM strobes
- Databus_out  out  DATA_W  muxed write data
- Burst_preempt  out  1  one-cycle pulse when a grant is revoked by burst limit

Function
REQ-006 SHALL implement FSM states IDLE, CPU_GNT, DMA_GNT, TURN.
REQ-007 Grants SHALL be registered, decoded from state only, and never high together.
REQ-008 In IDLE or TURN, a single request at edge N SHALL set the matching grant from N+1.
REQ-009 In IDLE or TURN with both requests high, the grant SHALL go to the master not served last (last_owner flop); last_owner resets to CPU, so DMA wins the first tie.
REQ-010 TURN with no request SHALL go to IDLE. TURN SHALL last exactly one cycle.
REQ-011 An owner dropping its request at edge N SHALL drop its grant at N+1 and enter TURN; the earliest next grant is N+2.
REQ-012 The burst counter SHALL clear on grant entry and increment each granted cycle, saturating at MAX_BURST-1.
REQ-013 With the counter at MAX_BURST-1 and the other request high, the FSM SHALL revoke the grant, enter TURN, pulse Burst_preempt for one cycle, and grant the other master in the next cycle.
REQ-014 With the counter saturated and no competing request, the owner SHALL keep the grant indefinitely.
REQ-015 A preempted master whose request stays high SHALL be re-granted only after the other master releases or is itself preempted.
REQ-016 Address/Cs/Wr_en/Oe/Databus_out SHALL combinationally follow the owner's inputs in CPU_GNT/DMA_GNT and SHALL be all-zero in IDLE and TURN.
REQ-017 A request deasserted before its grant edge SHALL get no grant; there is no queued request.

Reset
REQ-018 Rst high at an edge SHALL force state IDLE, both grants 0, counter 0, last_owner CPU, Burst_preempt 0, and all bus outputs 0 from the next cycle.
REQ-019 Reset during an active grant SHALL revoke it at that edge without a TURN cycle.
REQ-020 The first grant after reset release SHALL be no earlier than one cycle after Rst falls.

Structure
REQ-021 Package bus_arb_pkg SHALL hold the state_t enum (logic [1:0]) and the owner_t enum (CPU, DMA).
REQ-022 No sub-module is needed; the FSM, burst counter and output mux are inline.

Verification
REQ-023 Bench SHALL cover these scenarios:
- Lone CPU request: Cpu_bus_req=1 at cycle 5 -> Cpu_bus_grant=1 from cycle 6; Address=Cpu_address=8'h3C; release at cycle 10 -> grant 0 at 11, outputs 0.
- Tie after reset: both requests at cycle 3 -> Dma_bus_grant at 4; DMA releases at 7 -> TURN at 8, Cpu_bus_grant at 9.
- Burst limit (MAX_BURST=16): DMA granted at cycle 10 while CPU requesting -> DMA grant drops after 16 granted cycles, Burst_preempt pulses once, CPU granted the following cycle.
- No contention: DMA holds its request for 40 cycles -> grant stays high all 40 cycles, Burst_preempt never asserts.
- Reset mid-grant: Rst=1 while Cpu_bus_grant=1 -> next cycle both grants 0, Cs=0, Address=0; first grant after reset goes to DMA on a tie.
- Assertion over all tests: never (Cpu_bus_grant && Dma_bus_grant); Cs=0 whenever no grant is high.
